mem_req_to_apb_bridge: RTL and testbench

//  Converts the core-side req/gnt/rvalid memory protocol into single APB3 master transfers.

---
 rtl/mem_req_to_apb_bridge_if.sv | 45 ++++
 rtl/mem_req_to_apb_bridge.sv | 138 +++++++++++++
 tb/tb_mem_req_to_apb_bridge.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_to_apb_bridge_if.sv
// ---------------------------------------------------------------------------
// mem_req_to_apb_bridge_if
// Bundles the core-side req/gnt/rvalid memory port and the APB3 master port
// of the bridge into one interface.
//   slave  : bridge view (accepts core requests, drives the APB bus)
//   master : environment view (issues core requests, acts as APB completer)
// Signals:
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i   core request channel
//   rvalid_o/rdata_o/err_o                 core response channel
//   paddr/pwdata/pwrite/psel/penable       APB request (bridge -> bus)
//   prdata/pready/pslverr                  APB response (bus -> bridge)
// ---------------------------------------------------------------------------
interface mem_req_to_apb_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            req_i;
  logic            gnt_o;
  logic [AW-1:0]   addr_i;
  logic            we_i;
  logic [DW/8-1:0] be_i;
  logic [DW-1:0]   wdata_i;
  logic            rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            err_o;

  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic            pwrite;
  logic            psel;
  logic            penable;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, prdata, pready, pslverr,
    output gnt_o, rvalid_o, rdata_o, err_o, paddr, pwdata, pwrite, psel, penable
  );

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, prdata, pready, pslverr,
    input  gnt_o, rvalid_o, rdata_o, err_o, paddr, pwdata, pwrite, psel, penable
  );
endinterface

// File: rtl/mem_req_to_apb_bridge.sv
// ---------------------------------------------------------------------------
// mem_req_to_apb_bridge
// Converts single core req/gnt/rvalid memory accesses into APB3 master
// transfers, one outstanding transfer at a time. Requests outside the
// peripheral window, or writes with partial byte enables, are answered with
// an error response without touching APB. A stalled completer is aborted
// after TIMEOUT_CYCLES ACCESS cycles (0 disables the timeout).
// Ports:
//   clk  clock
//   rst  synchronous reset, active-high
//   bus  mem_req_to_apb_bridge_if.slave (core request/response + APB master)
// ---------------------------------------------------------------------------
module mem_req_to_apb_bridge #(
  parameter int          APB_ADDR_WIDTH = 32,
  parameter int          APB_DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h1A10_0000,
  parameter logic [31:0] WINDOW_SIZE    = 32'h0002_0000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_req_to_apb_bridge_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, RESP_ERR} state_t;

  // Window bounds carry one extra bit so BASE_ADDR+WINDOW_SIZE cannot wrap.
  localparam int                  AW1    = APB_ADDR_WIDTH + 1;
  localparam logic [AW1-1:0]      WIN_LO = AW1'(BASE_ADDR);
  localparam logic [AW1-1:0]      WIN_HI = AW1'(BASE_ADDR) + AW1'(WINDOW_SIZE);

  localparam int                  CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]       TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                         r_state;
  state_t                         w_next;

  logic [APB_ADDR_WIDTH-1:0]      r_paddr;
  logic [APB_DATA_WIDTH-1:0]      r_pwdata;
  logic                           r_pwrite;
  logic [APB_DATA_WIDTH-1:0]      r_rdata;
  logic                           r_err;
  logic [CW-1:0]                  r_cnt;

  logic                           w_in_window;
  logic                           w_illegal;
  logic                           w_timeout;

  assign w_in_window = ({1'b0, bus.addr_i} >= WIN_LO) && ({1'b0, bus.addr_i} < WIN_HI);
  assign w_illegal   = !w_in_window || (bus.we_i && !(&bus.be_i));
  // pready in the final allowed cycle still completes normally.
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && !bus.pready && (r_cnt == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned,
    // which would otherwise infer a latch.
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (bus.req_i) w_next = w_illegal ? RESP_ERR : SETUP;
      SETUP:    w_next = ACCESS;
      ACCESS:   if (bus.pready || w_timeout) w_next = RESP;
      RESP:     w_next = IDLE;
      RESP_ERR: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt_o    = 1'b0;
    bus.psel     = 1'b0;
    bus.penable  = 1'b0;
    bus.rvalid_o = 1'b0;
    unique case (r_state)
      IDLE:     bus.gnt_o    = bus.req_i && !rst;
      SETUP:    bus.psel     = 1'b1;
      ACCESS: begin
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
      end
      RESP:     bus.rvalid_o = 1'b1;
      RESP_ERR: bus.rvalid_o = 1'b1;
      default: ;
    endcase
  end

  // Request capture, response capture and the ACCESS wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.req_i) begin
            r_paddr  <= {bus.addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
            r_pwdata <= bus.wdata_i;
            r_pwrite <= bus.we_i;
            r_cnt    <= '0;
            if (w_illegal) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (bus.pready) begin
            r_rdata <= r_pwrite ? '0 : bus.prdata;
            r_err   <= bus.pslverr;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.paddr   = r_paddr;
  assign bus.pwdata  = r_pwdata;
  assign bus.pwrite  = r_pwrite;
  assign bus.rdata_o = r_rdata;
  assign bus.err_o   = r_err;

endmodule

// File: tb/tb_mem_req_to_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_req_to_apb_bridge
// Directed testbench for mem_req_to_apb_bridge (TIMEOUT_CYCLES = 4).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge. Expected values are hand-computed per transfer.
// ---------------------------------------------------------------------------
module tb_mem_req_to_apb_bridge;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_req_to_apb_bridge_if #(.AW(32), .DW(32)) bus ();

  mem_req_to_apb_bridge #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .BASE_ADDR      (32'h1A10_0000),
    .WINDOW_SIZE    (32'h0002_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_i   = 1'b0;
    bus.addr_i  = '0;
    bus.we_i    = 1'b0;
    bus.be_i    = '0;
    bus.wdata_i = '0;
    bus.prdata  = '0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
  endtask

  // Legal transfer. waits = ACCESS cycles before pready; exp_acc = expected
  // number of penable cycles (waits+1, or 4 when the timeout fires).
  task automatic apb_xfer(input string tag, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] be, input int waits,
                          input logic [31:0] prd, input logic slverr,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_acc);
    logic [31:0] exp_paddr;
    int acc;
    exp_paddr = {addr[31:2], 2'b00};
    // grant cycle
    bus.req_i = 1'b1; bus.addr_i = addr; bus.we_i = we; bus.wdata_i = wdata; bus.be_i = be;
    @(negedge clk);
    check({tag, ".gnt"}, bus.gnt_o, 1'b1);
    check({tag, ".psel_at_gnt"}, bus.psel, 1'b0);
    step();
    // SETUP; scramble request inputs to prove they were captured
    idle_inputs();
    bus.wdata_i = ~wdata;
    bus.addr_i  = ~addr;
    @(negedge clk);
    check({tag, ".setup_psel"}, bus.psel, 1'b1);
    check({tag, ".setup_penable"}, bus.penable, 1'b0);
    check({tag, ".setup_paddr"}, bus.paddr, exp_paddr);
    check({tag, ".setup_pwrite"}, bus.pwrite, we);
    if (we) check({tag, ".setup_pwdata"}, bus.pwdata, wdata);
    step();
    acc = 0;
    while (bus.penable && acc < 20) begin
      bus.pready  = (acc >= waits);
      bus.prdata  = bus.pready ? prd : 32'hDEAD_BEEF;
      bus.pslverr = bus.pready & slverr;
      @(negedge clk);
      acc++;
      check({tag, ".acc_psel"}, bus.psel, 1'b1);
      check({tag, ".acc_paddr"}, bus.paddr, exp_paddr);
      check({tag, ".acc_pwrite"}, bus.pwrite, we);
      if (we) check({tag, ".acc_pwdata"}, bus.pwdata, wdata);
      check({tag, ".acc_rvalid"}, bus.rvalid_o, 1'b0);
      step();
    end
    idle_inputs();
    check({tag, ".penable_cycles"}, 64'(acc), 64'(exp_acc));
    // response cycle
    @(negedge clk);
    check({tag, ".rvalid"}, bus.rvalid_o, 1'b1);
    check({tag, ".err"}, bus.err_o, exp_err);
    check({tag, ".rdata"}, bus.rdata_o, exp_rdata);
    check({tag, ".resp_psel"}, bus.psel, 1'b0);
    step();
    @(negedge clk);
    check({tag, ".rvalid_pulse"}, bus.rvalid_o, 1'b0);
    check({tag, ".rdata_hold"}, bus.rdata_o, exp_rdata);
    check({tag, ".err_hold"}, bus.err_o, exp_err);
    step();
  endtask

  // Rejected request: error response the next cycle, no APB activity.
  task automatic err_xfer(input string tag, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] be);
    bus.req_i = 1'b1; bus.addr_i = addr; bus.we_i = we; bus.wdata_i = wdata; bus.be_i = be;
    @(negedge clk);
    check({tag, ".gnt"}, bus.gnt_o, 1'b1);
    step();
    idle_inputs();
    @(negedge clk);
    check({tag, ".rvalid"}, bus.rvalid_o, 1'b1);
    check({tag, ".err"}, bus.err_o, 1'b1);
    check({tag, ".rdata"}, bus.rdata_o, 32'h0);
    check({tag, ".psel"}, bus.psel, 1'b0);
    step();
    @(negedge clk);
    check({tag, ".rvalid_pulse"}, bus.rvalid_o, 1'b0);
    check({tag, ".psel_after"}, bus.psel, 1'b0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst.gnt", bus.gnt_o, 1'b0);
    check("rst.psel", bus.psel, 1'b0);
    check("rst.penable", bus.penable, 1'b0);
    check("rst.rvalid", bus.rvalid_o, 1'b0);
    check("rst.rdata", bus.rdata_o, 32'h0);
    check("rst.err", bus.err_o, 1'b0);
    check("rst.paddr", bus.paddr, 32'h0);
    check("rst.pwdata", bus.pwdata, 32'h0);
    check("rst.pwrite", bus.pwrite, 1'b0);
    step();

    // Read, pready at first ACCESS cycle
    apb_xfer("t1_rd", 32'h1A10_1004, 1'b0, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 1'b0,
             1'b0, 32'hCAFE_F00D, 1);
    // Write, three wait cycles; pready coincides with the last allowed count
    apb_xfer("t2_wr", 32'h1A10_3000, 1'b1, 32'h1234_5678, 4'hF, 3, 32'hFFFF_FFFF, 1'b0,
             1'b0, 32'h0, 4);
    // Out-of-window read and partial-byte-enable write
    err_xfer("t3_oow", 32'h2000_0000, 1'b0, 32'h0, 4'hF);
    apb_xfer("b_rd_top", 32'h1A11_FFFF, 1'b0, 32'h0, 4'hF, 1, 32'h0BAD_CAFE, 1'b0,
             1'b0, 32'h0BAD_CAFE, 2);
    err_xfer("t4_be", 32'h1A10_0010, 1'b1, 32'hAAAA_5555, 4'h3);
    // Window edges, address wrap, partial be on a read is legal
    err_xfer("b_below", 32'h1A0F_FFFF, 1'b0, 32'h0, 4'hF);
    err_xfer("b_above", 32'h1A12_0000, 1'b0, 32'h0, 4'hF);
    err_xfer("b_wrap", 32'hFFFF_FFFF, 1'b0, 32'h0, 4'hF);
    apb_xfer("b_rd_be", 32'h1A10_0002, 1'b0, 32'h0, 4'h3, 0, 32'h1357_9BDF, 1'b0,
             1'b0, 32'h1357_9BDF, 1);
    // Timeout: pready never comes, penable for 4 cycles
    apb_xfer("t5_to", 32'h1A10_0008, 1'b0, 32'h0, 4'hF, 100, 32'h0, 1'b0,
             1'b1, 32'h0, 4);
    // Slave error
    apb_xfer("t6_slverr", 32'h1A10_0C00, 1'b0, 32'h0, 4'hF, 1, 32'h5555_AAAA, 1'b1,
             1'b1, 32'h5555_AAAA, 2);

    // Reset during ACCESS of a second transfer
    bus.req_i = 1'b1; bus.addr_i = 32'h1A10_0100; bus.we_i = 1'b0; bus.be_i = 4'hF;
    @(negedge clk);
    check("t6_rst.gnt", bus.gnt_o, 1'b1);
    step();
    idle_inputs();
    step();
    @(negedge clk);
    check("t6_rst.in_access", bus.penable, 1'b1);
    step();
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst.psel", bus.psel, 1'b0);
    check("t6_rst.penable", bus.penable, 1'b0);
    check("t6_rst.rvalid", bus.rvalid_o, 1'b0);
    check("t6_rst.rdata_cleared", bus.rdata_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("t6_rst.no_rvalid", bus.rvalid_o, 1'b0);
    end
    step();
    apb_xfer("t6_after", 32'h1A10_0204, 1'b1, 32'h0F0F_0F0F, 4'hF, 0, 32'h0, 1'b0,
             1'b0, 32'h0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
